// File: rtl/alarm_enable_ctrl.sv
// Avalon-MM alarm sequencer: time-of-day counter, alarm compare and the
// IDLE/ARMED/RINGING(/SNOOZE) FSM driving out_port. Define ALARM_SNOOZE_EN for the snooze feature.
module alarm_enable_ctrl #(
  parameter int TICKS_PER_SEC  = 50000000,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_DEFAULT = 300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [15:0]   RING_LIM = 16'(RING_SECONDS);
  localparam logic [15:0]   SNZ_RST  = 16'(SNOOZE_DEFAULT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_RING   = 2'd2,
    S_SNOOZE = 2'd3
  } state_t;

  function automatic logic time_ok(input logic [31:0] d);
    return (d[20:16] <= 5'd23) && (d[13:8] <= 6'd59) && (d[5:0] <= 6'd59);
  endfunction

  logic [2:0]    ctrl_q;
  logic [4:0]    hour_q, hour_d, al_hour_q;
  logic [5:0]    min_q, min_d, al_min_q;
  logic [5:0]    sec_q, sec_d, al_sec_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          time_chg_q, time_chg_d;
  logic          match_q, match_d;
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          out_port_q, irq_q;
`ifdef ALARM_SNOOZE_EN
  logic [15:0]   snooze_q;
  logic          snz_s;
`endif

  logic wr_s, wr_ctrl_s, wr_time_s, wr_alarm_s, wr_stat_s;
  logic time_load_s, sec_tick_s, run_s, arm_s, ack_s;

  assign wr_s        = chipselect & ~write_n;
  assign wr_ctrl_s   = wr_s && (address == 3'd0);
  assign wr_time_s   = wr_s && (address == 3'd1);
  assign wr_alarm_s  = wr_s && (address == 3'd2);
  assign wr_stat_s   = wr_s && (address == 3'd3);
  assign time_load_s = wr_time_s && time_ok(writedata);
  assign run_s       = ctrl_q[0];
  assign sec_tick_s  = run_s && (presc_q == PRE_MAX);
  // A CTRL write takes effect on the arm line at the same edge as the write.
  assign arm_s       = wr_ctrl_s ? writedata[1] : ctrl_q[1];
  assign ack_s       = wr_stat_s & writedata[0];
`ifdef ALARM_SNOOZE_EN
  assign snz_s       = wr_stat_s & writedata[1];
`endif

  // Prescaler and time-of-day next state; a legal TIME write beats the tick.
  always_comb begin
    presc_d    = presc_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    time_chg_d = 1'b0;
    if (time_load_s) begin
      presc_d    = '0;
      hour_d     = writedata[20:16];
      min_d      = writedata[13:8];
      sec_d      = writedata[5:0];
      time_chg_d = 1'b1;
    end else begin
      if (run_s) begin
        presc_d = (presc_q == PRE_MAX) ? '0 : presc_q + PW'(1);
      end else begin
        presc_d = presc_q;
      end
      if (sec_tick_s) begin
        time_chg_d = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == 6'd59) begin
            min_d  = 6'd0;
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        time_chg_d = 1'b0;
      end
    end
  end

  // Compare the freshly updated TIME against ALARM one clock after it changes.
  assign match_d = time_chg_q &&
                   ({hour_q, min_q, sec_q} == {al_hour_q, al_min_q, al_sec_q});

  // Alarm FSM next state, ring/snooze counter and pending flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (!arm_s) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARMED;
        S_ARMED: begin
          if (match_q) begin
            state_d = S_RING;
            pend_d  = 1'b1;
            cnt_d   = 16'd0;
          end else begin
            state_d = S_ARMED;
          end
        end
        S_RING: begin
          if (ack_s) begin
            state_d = S_ARMED;
            pend_d  = 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (snz_s) begin
            state_d = S_SNOOZE;
            cnt_d   = snooze_q;
            pend_d  = 1'b0;
`endif
          end else if (sec_tick_s) begin
            if ((cnt_q + 16'd1) >= RING_LIM) begin
              state_d = S_ARMED;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end else begin
            state_d = S_RING;
          end
        end
`ifdef ALARM_SNOOZE_EN
        S_SNOOZE: begin
          if (ack_s) begin
            state_d = S_ARMED;
            pend_d  = 1'b0;
          end else if (sec_tick_s) begin
            if (cnt_q <= 16'd1) begin
              state_d = S_RING;
              pend_d  = 1'b1;
              cnt_d   = 16'd0;
            end else begin
              cnt_d = cnt_q - 16'd1;
            end
          end else begin
            state_d = S_SNOOZE;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= 3'd0;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      al_hour_q  <= 5'd0;
      al_min_q   <= 6'd0;
      al_sec_q   <= 6'd0;
      presc_q    <= '0;
      time_chg_q <= 1'b0;
      match_q    <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      pend_q     <= 1'b0;
      out_port_q <= 1'b0;
      irq_q      <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snooze_q   <= SNZ_RST;
`endif
    end else begin
      if (wr_ctrl_s) ctrl_q <= writedata[2:0];
      if (wr_alarm_s && time_ok(writedata)) begin
        al_hour_q <= writedata[20:16];
        al_min_q  <= writedata[13:8];
        al_sec_q  <= writedata[5:0];
      end
`ifdef ALARM_SNOOZE_EN
      if (wr_s && (address == 3'd4)) snooze_q <= writedata[15:0];
`endif
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      presc_q    <= presc_d;
      time_chg_q <= time_chg_d;
      match_q    <= match_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      out_port_q <= (state_d == S_RING);
      irq_q      <= ctrl_q[2] & pend_q;
    end
  end

`ifndef ALARM_SNOOZE_EN
  logic unused_snz_s;
  assign unused_snz_s = ^SNZ_RST;
`endif

  // Zero-latency register read mux.
  always_comb begin
    readdata = 32'd0;
    case (address)
      3'd0: readdata = {29'd0, ctrl_q};
      3'd1: readdata = {11'd0, hour_q, 2'd0, min_q, 2'd0, sec_q};
      3'd2: readdata = {11'd0, al_hour_q, 2'd0, al_min_q, 2'd0, al_sec_q};
      3'd3: readdata = {27'd0, pend_q, 2'd0, state_q};
`ifdef ALARM_SNOOZE_EN
      3'd4: readdata = {16'd0, snooze_q};
`endif
      default: readdata = 32'd0;
    endcase
  end

  assign out_port = out_port_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_alarm_enable_ctrl.sv
// Scoreboard bench for alarm_enable_ctrl with TICKS_PER_SEC=4, RING_SECONDS=2.
module tb_alarm_enable_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_port;
  logic        irq;

  alarm_enable_ctrl #(
    .TICKS_PER_SEC(4), .RING_SECONDS(2), .SNOOZE_DEFAULT(300)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

`ifdef ALARM_SNOOZE_EN
  localparam logic [31:0] SNZ_EXP = 32'd300;
`else
  localparam logic [31:0] SNZ_EXP = 32'd0;
`endif

  typedef struct {
    string       nm;
    int          kind;   // 0 readdata, 1 out_port, 2 irq
    logic [31:0] exp;
    logic [31:0] mask;
  } ent_t;

  ent_t        sb[$];
  ent_t        me;
  logic [31:0] act;
  int          total_n = 0;
  int          bad_n   = 0;

  // Monitor: drain pending expectations against the outputs at each falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      me = sb.pop_front();
      case (me.kind)
        0:       act = readdata;
        1:       act = {31'd0, out_port};
        default: act = {31'd0, irq};
      endcase
      total_n++;
      if ((act & me.mask) !== (me.exp & me.mask)) begin
        bad_n++;
        $display("FAIL %s: got 0x%08h want 0x%08h (mask 0x%08h)", me.nm, act, me.exp, me.mask);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    if (clk) @(negedge clk);
    #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Only one register check per clock; out/irq checks go before it.
  task automatic chk_rd(input logic [2:0] a, input logic [31:0] e,
                        input logic [31:0] m, input string nm);
    ent_t x;
    address = a; chipselect = 1'b1; write_n = 1'b1;
    x.nm = nm; x.kind = 0; x.exp = e; x.mask = m;
    sb.push_back(x);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_bit(input int k, input logic v, input string nm);
    ent_t x;
    x.nm = nm; x.kind = k; x.exp = {31'd0, v}; x.mask = 32'd1;
    sb.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  initial begin
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    step(2);
    reset = 1'b0;
    // reset state
    chk_bit(1, 1'b0, "out_rst"); chk_bit(2, 1'b0, "irq_rst");
    chk_rd(3'd0, 32'd0, ALL, "ctrl_rst"); step(1);
    chk_rd(3'd1, 32'd0, ALL, "time_rst"); step(1);
    chk_rd(3'd2, 32'd0, ALL, "alarm_rst"); step(1);
    chk_rd(3'd3, 32'd0, ALL, "status_rst"); step(1);
    chk_rd(3'd4, SNZ_EXP, ALL, "snooze_rst"); step(1);

    // midnight rollover and illegal TIME writes
    wr(3'd1, 32'h0017_3B3A);
    chk_rd(3'd1, 32'h0017_3B3A, ALL, "time_load");
    wr(3'd0, 32'd1);
    step(7);
    chk_rd(3'd1, 32'h0017_3B3B, ALL, "time_sec59");
    step(1);
    chk_rd(3'd1, 32'd0, ALL, "time_midnight");
    wr(3'd1, 32'h0000_003C); chk_rd(3'd1, 32'd0, ALL, "bad_sec");
    wr(3'd1, 32'h0000_3C00); chk_rd(3'd1, 32'd0, ALL, "bad_min");
    wr(3'd1, 32'h0018_0000); chk_rd(3'd1, 32'd0, ALL, "bad_hour");

    // alarm match at 00:00:03
    wr(3'd0, 32'd0);
    wr(3'd2, 32'd3);
    chk_rd(3'd2, 32'd3, ALL, "alarm_rd");
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd7);
    step(11);
    chk_rd(3'd1, 32'd2, ALL, "time_2");
    step(1);
    chk_bit(1, 1'b0, "out_pre1");
    chk_rd(3'd1, 32'd3, ALL, "time_match");
    step(1);
    chk_bit(1, 1'b0, "out_pre2");
    chk_rd(3'd3, 32'h01, ALL, "state_armed");
    step(1);
    chk_bit(1, 1'b1, "out_ring"); chk_bit(2, 1'b0, "irq_lag");
    chk_rd(3'd3, 32'h12, ALL, "state_ring");
    step(1);
    chk_bit(2, 1'b1, "irq_set");

    // ack while ringing
    wr(3'd3, 32'h1);
    chk_bit(1, 1'b0, "out_ack");
    chk_rd(3'd3, 32'h01, ALL, "state_ack");
    step(1);
    chk_bit(2, 1'b0, "irq_clr");

    // ring timeout after RING_SECONDS
    wr(3'd1, 32'd0);
    step(14);
    chk_bit(1, 1'b1, "out_ring2");
    step(5);
    chk_bit(1, 1'b1, "out_before_to");
    chk_rd(3'd3, 32'd2, 32'h3, "ring_before_to");
    step(1);
    chk_bit(1, 1'b0, "out_timeout");
    chk_rd(3'd3, 32'd1, 32'h3, "timeout_armed");

    // snooze
    wr(3'd1, 32'd0);
    step(14);
    chk_bit(1, 1'b1, "out_ring3");
    wr(3'd4, 32'd2);
    wr(3'd3, 32'h2);
`ifdef ALARM_SNOOZE_EN
    chk_bit(1, 1'b0, "out_snz");
    chk_rd(3'd3, 32'h03, ALL, "state_snz");
    step(7);
    chk_rd(3'd3, 32'h03, ALL, "snz_hold");
    step(1);
    chk_bit(1, 1'b1, "out_resume");
    chk_rd(3'd3, 32'h12, ALL, "snz_expire");
    wr(3'd3, 32'h3);
    chk_rd(3'd3, 32'h01, ALL, "ack_and_snz");
    step(1);
    chk_rd(3'd4, 32'd2, ALL, "snooze_rd");
`else
    chk_bit(1, 1'b1, "out_no_snz");
    chk_rd(3'd3, 32'h12, ALL, "state_no_snz");
    wr(3'd3, 32'h3);
    chk_rd(3'd3, 32'h01, ALL, "ack_and_snz");
    step(1);
    chk_rd(3'd4, 32'd0, ALL, "snooze_rd");
`endif

    // disarm while ringing
    wr(3'd1, 32'd0);
    step(14);
    chk_bit(1, 1'b1, "out_ring4");
    wr(3'd0, 32'd1);
    chk_bit(1, 1'b0, "out_disarm");
    chk_rd(3'd3, 32'h00, ALL, "state_idle");

    // reset mid-operation
    wr(3'd0, 32'd7);
    wr(3'd1, 32'd0);
    step(14);
    chk_bit(1, 1'b1, "out_ring5");
`ifdef ALARM_SNOOZE_EN
    wr(3'd3, 32'h2);
    chk_rd(3'd3, 32'h03, ALL, "pre_rst_snz");
`else
    chk_bit(2, 1'b0, "irq_pre_rst_lag");
`endif
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_bit(1, 1'b0, "out_rst2"); chk_bit(2, 1'b0, "irq_rst2");
    chk_rd(3'd0, 32'd0, ALL, "ctrl_rst2"); step(1);
    chk_rd(3'd1, 32'd0, ALL, "time_rst2"); step(1);
    chk_rd(3'd2, 32'd0, ALL, "alarm_rst2"); step(1);
    chk_rd(3'd3, 32'd0, ALL, "status_rst2"); step(1);
    chk_rd(3'd4, SNZ_EXP, ALL, "snooze_rst2");
    step(2);

    total_n++;
    if (sb.size() != 0) begin
      bad_n++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
